// File: rtl/mem_beat_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mem_bridge_pkg
// Shared types and constants for the L2-to-beat-bus bridge.
//   bridge_state_t : controller states
//   BEATS/LG_BEATS : beat count of the default 512-bit line over a 64-bit bus
//   MEM_LW/MEM_SW  : memory-port opcodes, mirrored from the machine defines
// No ports (package).
// ---------------------------------------------------------------------------
package mem_bridge_pkg;

    localparam int LINE_W_DFLT = 512;
    localparam int BEAT_W_DFLT = 64;
    localparam int BEATS       = LINE_W_DFLT / BEAT_W_DFLT;
    localparam int LG_BEATS    = $clog2(BEATS);

    // Opcode encodings as used on the L2 memory port.
    localparam logic [3:0] MEM_LW = 4'h2;
    localparam logic [3:0] MEM_SW = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RDATA,
        WDATA,
        WRESP,
        DONE
    } bridge_state_t;

endpackage

// File: rtl/mem_beat_bridge_if.sv
// ---------------------------------------------------------------------------
// mem_beat_bridge_if
// Bundles the L2 line-request port and the beat-bus port of the bridge.
//   slave  : the bridge's view (takes line requests, drives the bus)
//   master : the environment's view (L2 side plus bus responder)
// Signals:
//   mem_req_*      line request from L2 (valid pulse, addr, opcode, store line)
//   mem_req_ack    request captured
//   mem_rsp_*      completion pulse and assembled load line
//   bus_req_*      address phase (valid/ready, aligned addr, write flag)
//   bus_w*         write beats (valid/ready, data, last)
//   bus_bvalid     write response
//   bus_r*         read beats (valid, data, last); always accepted
// ---------------------------------------------------------------------------
interface mem_beat_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64
);
    logic                mem_req_valid;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [LINE_W-1:0]   mem_req_store_data;
    logic [3:0]          mem_req_opcode;
    logic                mem_req_ack;
    logic                mem_rsp_valid;
    logic [LINE_W-1:0]   mem_rsp_load_data;

    logic                bus_req_valid;
    logic                bus_req_ready;
    logic [ADDR_W-1:0]   bus_req_addr;
    logic                bus_req_write;
    logic                bus_wvalid;
    logic                bus_wready;
    logic [BEAT_W-1:0]   bus_wdata;
    logic                bus_wlast;
    logic                bus_bvalid;
    logic                bus_rvalid;
    logic [BEAT_W-1:0]   bus_rdata;
    logic                bus_rlast;

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode,
        input  bus_req_ready, bus_wready, bus_bvalid, bus_rvalid, bus_rdata, bus_rlast,
        output mem_req_ack, mem_rsp_valid, mem_rsp_load_data,
        output bus_req_valid, bus_req_addr, bus_req_write,
        output bus_wvalid, bus_wdata, bus_wlast
    );

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode,
        output bus_req_ready, bus_wready, bus_bvalid, bus_rvalid, bus_rdata, bus_rlast,
        input  mem_req_ack, mem_rsp_valid, mem_rsp_load_data,
        input  bus_req_valid, bus_req_addr, bus_req_write,
        input  bus_wvalid, bus_wdata, bus_wlast
    );

endinterface

// File: rtl/mem_beat_bridge_line_shift_buf.sv
// ---------------------------------------------------------------------------
// line_shift_buf
// One line of storage shared by the load and store paths: a store line is
// loaded whole and read out beat by beat; a load line is written beat by beat.
// Ports:
//   clk          clock
//   i_load_en    load the whole line from i_load_line (has priority)
//   i_wr_en      write i_wr_beat into slot i_wr_idx
//   i_rd_idx     slot presented on o_rd_beat (combinational read)
//   o_line       current line contents
// Line contents carry no reset: every use overwrites them before reading.
// ---------------------------------------------------------------------------
module line_shift_buf #(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    parameter int LG     = 3
) (
    input  logic              clk,
    input  logic              i_load_en,
    input  logic [LINE_W-1:0] i_load_line,
    input  logic              i_wr_en,
    input  logic [LG-1:0]     i_wr_idx,
    input  logic [BEAT_W-1:0] i_wr_beat,
    input  logic [LG-1:0]     i_rd_idx,
    output logic [BEAT_W-1:0] o_rd_beat,
    output logic [LINE_W-1:0] o_line
);

    logic [LINE_W-1:0] r_line;

    always_ff @(posedge clk) begin
        if (i_load_en) begin
            r_line <= i_load_line;
        end else if (i_wr_en) begin
            r_line[i_wr_idx*BEAT_W +: BEAT_W] <= i_wr_beat;
        end
    end

    assign o_rd_beat = r_line[i_rd_idx*BEAT_W +: BEAT_W];
    assign o_line    = r_line;

endmodule

// File: rtl/mem_beat_bridge.sv
// ---------------------------------------------------------------------------
// mem_beat_bridge
// Turns single-pulse full-line L2 memory requests into beat transfers on an
// external bus and reassembles load beats into a line. One transaction in
// flight at a time.
// Ports:
//   clk        clock
//   reset      asynchronous, active-low reset
//   bus        mem_beat_bridge_if.slave (L2 request/response + beat bus)
//   proto_err  sticky protocol-error flag, cleared only by reset
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_beat_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = LINE_W_DFLT,
    parameter int BEAT_W = BEAT_W_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_beat_bridge_if.slave     bus,
    output logic                 proto_err
);

    localparam int NB  = LINE_W / BEAT_W;
    localparam int LG  = $clog2(NB);
    localparam int OFF = $clog2(LINE_W / 8);

    bridge_state_t     r_state;
    logic [3:0]        r_op;
    logic [LG-1:0]     r_beat;
    logic              r_ack;
    logic              r_rsp_valid;
    logic [LINE_W-1:0] r_rsp_data;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_req_write;
    logic              r_wvalid;
    logic [BEAT_W-1:0] r_wdata;
    logic              r_wlast;
    logic              r_err;

    logic              w_w_hs;
    logic              w_last;
    logic [LG-1:0]     w_next_beat;
    logic [LG-1:0]     w_rd_idx;
    logic [BEAT_W-1:0] w_rd_beat;
    logic [LINE_W-1:0] w_line;
    logic              w_buf_load;
    logic              w_buf_wr;
    logic              w_op_ok;

    assign w_w_hs      = (r_state == WDATA) && r_wvalid && bus.bus_wready;
    assign w_last      = (r_beat == LG'(NB - 1));
    assign w_next_beat = r_beat + 1'b1;   // wraps to 0 after the last beat
    // Pre-fetch the beat that becomes current after this edge, so bus_wdata
    // can be registered without a bus-input-to-output combinational path.
    assign w_rd_idx    = w_w_hs ? w_next_beat : '0;
    assign w_buf_load  = (r_state == IDLE) && bus.mem_req_valid;
    assign w_buf_wr    = (r_state == RDATA) && bus.bus_rvalid;
    assign w_op_ok     = (bus.mem_req_opcode == MEM_LW) || (bus.mem_req_opcode == MEM_SW);

    line_shift_buf #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .LG     (LG)
    ) u_buf (
        .clk         (clk),
        .i_load_en   (w_buf_load),
        .i_load_line (bus.mem_req_store_data),
        .i_wr_en     (w_buf_wr),
        .i_wr_idx    (r_beat),
        .i_wr_beat   (bus.bus_rdata),
        .i_rd_idx    (w_rd_idx),
        .o_rd_beat   (w_rd_beat),
        .o_line      (w_line)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_beat      <= '0;
            r_ack       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_write <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wlast     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_rsp_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.mem_req_valid) begin
                        r_ack <= 1'b1;
                        r_op  <= bus.mem_req_opcode;
                        if (w_op_ok) begin
                            r_state     <= ADDR;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {bus.mem_req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                            r_req_write <= (bus.mem_req_opcode == MEM_SW);
                        end else begin
                            // Unknown opcode: complete without touching the bus.
                            r_state <= DONE;
                            r_err   <= 1'b1;
                        end
                    end
                end

                ADDR: begin
                    if (bus.bus_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_beat      <= '0;
                        if (r_op == MEM_SW) begin
                            r_state  <= WDATA;
                            r_wvalid <= 1'b1;
                            r_wdata  <= w_rd_beat;
                            r_wlast  <= 1'b0;
                        end else begin
                            r_state <= RDATA;
                        end
                    end
                end

                WDATA: begin
                    if (w_w_hs) begin
                        r_beat <= w_next_beat;
                        if (w_last) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_state  <= WRESP;
                        end else begin
                            r_wdata <= w_rd_beat;
                            r_wlast <= (w_next_beat == LG'(NB - 1));
                        end
                    end
                end

                WRESP: begin
                    if (bus.bus_bvalid) begin
                        r_state <= DONE;
                    end
                end

                RDATA: begin
                    if (bus.bus_rvalid) begin
                        r_beat <= w_next_beat;
                        if (w_last) begin
                            // Finish on beat count even if rlast disagrees.
                            r_state <= DONE;
                            if (!bus.bus_rlast) begin
                                r_err <= 1'b1;
                            end
                        end else if (bus.bus_rlast) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                    if (r_op == MEM_LW) begin
                        r_rsp_data <= w_line;
                    end
                end

                default: r_state <= IDLE;
            endcase

            // Stray traffic: requests while busy are dropped, bus responses
            // with nothing expecting them are ignored; all are flagged.
            if (bus.mem_req_valid && (r_state != IDLE)) begin
                r_err <= 1'b1;
            end
            if (bus.bus_rvalid && (r_state != RDATA)) begin
                r_err <= 1'b1;
            end
            if (bus.bus_bvalid && (r_state != WRESP)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_req_ack       = r_ack;
    assign bus.mem_rsp_valid     = r_rsp_valid;
    assign bus.mem_rsp_load_data = r_rsp_data;
    assign bus.bus_req_valid     = r_req_valid;
    assign bus.bus_req_addr      = r_req_addr;
    assign bus.bus_req_write     = r_req_write;
    assign bus.bus_wvalid        = r_wvalid;
    assign bus.bus_wdata         = r_wdata;
    assign bus.bus_wlast         = r_wlast;
    assign proto_err             = r_err;

endmodule

// File: tb/tb_mem_beat_bridge.sv
`timescale 1ns/1ps
module tb_mem_beat_bridge;
    import mem_bridge_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int BEAT_W = 64;
    localparam int NB     = BEATS;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic proto_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_req  = 0;

    mem_beat_bridge_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bif ();

    mem_beat_bridge #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif.slave),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [BEAT_W-1:0] base);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < NB; i++) l[i*BEAT_W +: BEAT_W] = base + BEAT_W'(i);
        return l;
    endfunction

    // Present a one-cycle request and check the registered ack.
    task automatic start_req(input logic [ADDR_W-1:0] a, input logic [3:0] op, input logic [LINE_W-1:0] d);
        bif.mem_req_valid      = 1'b1;
        bif.mem_req_addr       = a;
        bif.mem_req_opcode     = op;
        bif.mem_req_store_data = d;
        t_req = cyc;
        step();
        bif.mem_req_valid = 1'b0;
        check("req_ack", bif.mem_req_ack, 1'b1);
    endtask

    // Return NB read beats base+i, rlast on beat rlast_at, gap idle cycles between beats.
    task automatic run_beats(input logic [BEAT_W-1:0] base, input int rlast_at, input int gap);
        for (int i = 0; i < NB; i++) begin
            bif.bus_rvalid = 1'b1;
            bif.bus_rdata  = base + BEAT_W'(i);
            bif.bus_rlast  = (i == rlast_at);
            step();
            bif.bus_rvalid = 1'b0;
            bif.bus_rlast  = 1'b0;
            check("no_early_rsp", bif.mem_rsp_valid, 1'b0);
            if (i < NB - 1) repeat (gap) step();
        end
    endtask

    task automatic wait_rsp(input int exp_lat);
        for (int k = 0; k < 30 && !bif.mem_rsp_valid; k++) step();
        check("rsp_seen", bif.mem_rsp_valid, 1'b1);
        check("rsp_latency", 32'(cyc - t_req), 32'(exp_lat));
    endtask

    logic [LINE_W-1:0] st_line;
    int got;
    logic wr_t;

    initial begin
        bif.mem_req_valid      = 1'b0;
        bif.mem_req_addr       = '0;
        bif.mem_req_opcode     = '0;
        bif.mem_req_store_data = '0;
        bif.bus_req_ready      = 1'b0;
        bif.bus_wready         = 1'b0;
        bif.bus_bvalid         = 1'b0;
        bif.bus_rvalid         = 1'b0;
        bif.bus_rdata          = '0;
        bif.bus_rlast          = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ack", bif.mem_req_ack, 1'b0);
        check("rst_rsp_valid", bif.mem_rsp_valid, 1'b0);
        check("rst_req_valid", bif.bus_req_valid, 1'b0);
        check("rst_wvalid", bif.bus_wvalid, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_rsp_data", bif.mem_rsp_load_data, '0);
        reset = 1'b1;
        step();

        // Load, no stalls
        bif.bus_req_ready = 1'b1;
        start_req(32'h1000_0047, MEM_LW, '0);
        check("ld1_req_valid", bif.bus_req_valid, 1'b1);
        check("ld1_req_addr", bif.bus_req_addr, 32'h1000_0040);
        check("ld1_req_write", bif.bus_req_write, 1'b0);
        step();
        check("ld1_req_valid_drop", bif.bus_req_valid, 1'b0);
        run_beats(64'h0, 7, 0);
        wait_rsp(11);
        check("ld1_data", bif.mem_rsp_load_data, mk_line(64'h0));
        check("ld1_proto_err", proto_err, 1'b0);
        step();
        check("ld1_rsp_pulse", bif.mem_rsp_valid, 1'b0);

        // Store with address backpressure and wready stalls
        bif.bus_req_ready = 1'b0;
        st_line = mk_line(64'hC0DE_0000_0000_0000);
        start_req(32'h2000_0010, MEM_SW, st_line);
        check("st_req_valid", bif.bus_req_valid, 1'b1);
        check("st_req_write", bif.bus_req_write, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_req_valid", bif.bus_req_valid, 1'b1);
            check("bp_req_addr", bif.bus_req_addr, 32'h2000_0000);
            check("bp_req_write", bif.bus_req_write, 1'b1);
            check("bp_no_wvalid", bif.bus_wvalid, 1'b0);
        end
        bif.bus_req_ready = 1'b1;
        step();
        bif.bus_req_ready = 1'b0;
        check("st_req_valid_drop", bif.bus_req_valid, 1'b0);
        got  = 0;
        wr_t = 1'b1;
        for (int c = 0; c < 40 && got < NB; c++) begin
            bif.bus_wready = wr_t;
            check("st_wvalid_held", bif.bus_wvalid, 1'b1);
            if (wr_t) begin
                check("st_wdata", bif.bus_wdata, 64'hC0DE_0000_0000_0000 + 64'(got));
                check("st_wlast", bif.bus_wlast, (got == NB - 1));
                got++;
            end
            step();
            wr_t = !wr_t;
        end
        bif.bus_wready = 1'b0;
        check("st_beat_count", 32'(got), 32'(NB));
        check("st_wvalid_drop", bif.bus_wvalid, 1'b0);
        step();
        step();
        bif.bus_bvalid = 1'b1;
        step();
        bif.bus_bvalid = 1'b0;
        check("st_rsp_done_cycle", bif.mem_rsp_valid, 1'b0);
        step();
        check("st_rsp_valid", bif.mem_rsp_valid, 1'b1);
        check("st_rsp_data_kept", bif.mem_rsp_load_data, mk_line(64'h0));
        check("st_proto_err", proto_err, 1'b0);

        // Back-to-back load, one idle cycle between beats
        step();
        bif.bus_req_ready = 1'b1;
        start_req(32'h3000_0080, MEM_LW, '0);
        check("b2b_req_addr", bif.bus_req_addr, 32'h3000_0080);
        step();
        run_beats(64'hFEED_0000_0000_0000, 7, 1);
        wait_rsp(11 + 7);
        check("b2b_data", bif.mem_rsp_load_data, mk_line(64'hFEED_0000_0000_0000));
        check("b2b_proto_err", proto_err, 1'b0);

        // Early rlast on beat 3
        step();
        start_req(32'h4000_0000, MEM_LW, '0);
        step();
        run_beats(64'h0BAD_0000_0000_0000, 3, 0);
        check("early_proto_err", proto_err, 1'b1);
        wait_rsp(11);
        check("early_data", bif.mem_rsp_load_data, mk_line(64'h0BAD_0000_0000_0000));

        // Reset during RDATA beat 4
        step();
        start_req(32'h5000_0000, MEM_LW, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            bif.bus_rvalid = 1'b1;
            bif.bus_rdata  = 64'(i);
            step();
        end
        bif.bus_rdata = 64'h4;
        #1;
        reset = 1'b0;
        #1;
        check("mrst_req_addr", bif.bus_req_addr, '0);
        check("mrst_wdata", bif.bus_wdata, '0);
        check("mrst_rsp_data", bif.mem_rsp_load_data, '0);
        check("mrst_proto_err", proto_err, 1'b0);
        check("mrst_valids", {bif.mem_req_ack, bif.mem_rsp_valid, bif.bus_req_valid,
                              bif.bus_req_write, bif.bus_wvalid, bif.bus_wlast}, '0);
        bif.bus_rvalid = 1'b0;
        step();
        reset = 1'b1;
        step();
        start_req(32'h6000_0100, MEM_LW, '0);
        check("post_rst_addr", bif.bus_req_addr, 32'h6000_0100);
        step();
        run_beats(64'h6000_0000_0000_0000, 7, 0);
        wait_rsp(11);
        check("post_rst_data", bif.mem_rsp_load_data, mk_line(64'h6000_0000_0000_0000));
        check("post_rst_proto_err", proto_err, 1'b0);

        // Unsupported opcode: no bus traffic, error flagged, response still sent
        step();
        start_req(32'h7000_0000, 4'hF, '0);
        check("badop_no_req", bif.bus_req_valid, 1'b0);
        step();
        check("badop_rsp", bif.mem_rsp_valid, 1'b1);
        check("badop_proto_err", proto_err, 1'b1);
        check("badop_data_kept", bif.mem_rsp_load_data, mk_line(64'h6000_0000_0000_0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
